// File: rtl/irq_controller.sv
// Prioritised interrupt controller: synchronised edge/level capture, per-channel mask,
// and a one-at-a-time request/service handshake toward the CPU.
module irq_controller #(
    parameter int unsigned NUM_IRQ     = 4,
    parameter int unsigned VEC_WIDTH   = 10,
    parameter int unsigned BASE_VECTOR = 'h3F0,
    parameter int unsigned VEC_STRIDE  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_IRQ-1:0]   irq_in,
    input  logic                 cfg_we,
    input  logic [NUM_IRQ-1:0]   cfg_mask,
    input  logic [NUM_IRQ-1:0]   cfg_mode,
    input  logic                 irq_ack,
    input  logic                 irq_ret,
    output logic                 irq_req,
    output logic [VEC_WIDTH-1:0] irq_vec,
    output logic [3:0]           irq_id,
    output logic                 in_service,
    output logic [NUM_IRQ-1:0]   pending
);

    typedef enum logic [1:0] {StIdle, StRequest, StService} state_e;

    state_e               state_q;
    logic [NUM_IRQ-1:0]   sync1_q, sync2_q, prev_q;
    logic [NUM_IRQ-1:0]   mask_q, mode_q, pending_q, pending_d;
    logic [NUM_IRQ-1:0]   rise, ack_clr, eligible;
    logic [1:0]           warm_q;
    logic                 irq_req_q, in_service_q;
    logic [VEC_WIDTH-1:0] irq_vec_q, sel_vec;
    logic [3:0]           irq_id_q, sel_id;

    // prev_q resets high and freezes until the synchroniser has refilled, so a line that
    // is already high at reset release never looks like a fresh edge.
    always_comb begin
        rise      = sync2_q & ~prev_q;
        eligible  = pending_q & mask_q;
        ack_clr   = '0;
        pending_d = '0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            ack_clr[i]   = (state_q == StRequest) && irq_ack && (irq_id_q == 4'(i));
            pending_d[i] = mode_q[i] ? (rise[i] | (pending_q[i] & ~ack_clr[i])) : sync2_q[i];
        end
        sel_id = 4'd0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) sel_id = 4'(i);
        end
        sel_vec = VEC_WIDTH'(BASE_VECTOR + 32'(sel_id) * VEC_STRIDE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '1;
            warm_q    <= 2'b00;
            mask_q    <= '1;
            mode_q    <= '1;
            pending_q <= '0;
        end else begin
            sync1_q   <= irq_in;
            sync2_q   <= sync1_q;
            warm_q    <= {warm_q[0], 1'b1};
            prev_q    <= warm_q[1] ? sync2_q : prev_q;
            pending_q <= pending_d;
            if (cfg_we) begin
                mask_q <= cfg_mask;
                mode_q <= cfg_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            irq_req_q    <= 1'b0;
            in_service_q <= 1'b0;
            irq_vec_q    <= '0;
            irq_id_q     <= 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (eligible != '0) begin
                        state_q   <= StRequest;
                        irq_req_q <= 1'b1;
                        irq_id_q  <= sel_id;
                        irq_vec_q <= sel_vec;
                    end
                end
                StRequest: begin
                    if (irq_ack) begin
                        state_q      <= StService;
                        irq_req_q    <= 1'b0;
                        in_service_q <= 1'b1;
                    end
                end
                StService: begin
                    if (irq_ret) begin
                        state_q      <= StIdle;
                        in_service_q <= 1'b0;
                        irq_vec_q    <= '0;
                        irq_id_q     <= 4'd0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign irq_req    = irq_req_q;
    assign irq_vec    = irq_vec_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;

endmodule
